// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - command-side sequencer for the accumulating calculator
// Clears the calculator, streams operands in as load/add strobes and captures the checked result.
module calc_sequencer #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              busy,
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_data,
  output logic              op_ready,
  output logic [DATA_W-1:0] calc_dIn,
  output logic              calc_clear,
  output logic              calc_load,
  output logic              calc_add,
  input  logic [RES_W-1:0]  calc_result,
  output logic [RES_W-1:0]  sum,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCEPT, ISSUE, SETTLE, CAPTURE
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  remaining, remaining_d;
  logic              first, first_d;
  logic [RES_W-1:0]  shadow, shadow_d, sum_d, operand_ext;
  logic [DATA_W-1:0] dIn_d;
  logic              busy_d, op_ready_d, clear_d, load_d, add_d, done_d, err_d;
  logic              aborting, take;

  assign aborting    = abort && (state != IDLE);
  assign take        = (state == ACCEPT) && op_valid && !aborting;
  assign operand_ext = {{(RES_W-DATA_W){1'b0}}, op_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      first      <= 1'b0;
      shadow     <= '0;
      busy       <= 1'b0;
      op_ready   <= 1'b0;
      calc_dIn   <= '0;
      calc_clear <= 1'b0;
      calc_load  <= 1'b0;
      calc_add   <= 1'b0;
      sum        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      remaining  <= remaining_d;
      first      <= first_d;
      shadow     <= shadow_d;
      busy       <= busy_d;
      op_ready   <= op_ready_d;
      calc_dIn   <= dIn_d;
      calc_clear <= clear_d;
      calc_load  <= load_d;
      calc_add   <= add_d;
      sum        <= sum_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    next_state = state;
    if (aborting) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = CLEAR;
        CLEAR:   next_state = (remaining == '0) ? SETTLE : ACCEPT;
        ACCEPT:  if (op_valid) next_state = ISSUE;
        ISSUE:   next_state = (remaining == '0) ? SETTLE : ACCEPT;
        SETTLE:  next_state = CAPTURE;
        CAPTURE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered, so each one is derived from the state being entered.
  always_comb begin
    remaining_d = remaining;
    first_d     = first;
    shadow_d    = shadow;
    dIn_d       = calc_dIn;
    sum_d       = sum;
    err_d       = err;
    busy_d      = (next_state != IDLE);
    op_ready_d  = (next_state == ACCEPT);
    clear_d     = aborting || (next_state == CLEAR);
    load_d      = 1'b0;
    add_d       = 1'b0;
    done_d      = (next_state == CAPTURE);
    case (state)
      IDLE: begin
        if (start) begin
          remaining_d = count;
          first_d     = 1'b1;
          shadow_d    = '0;
        end
      end
      ACCEPT: begin
        if (take) begin
          dIn_d       = op_data;
          remaining_d = remaining - 1'b1;
          load_d      = first;
          add_d       = !first;
          shadow_d    = first ? operand_ext : shadow + operand_ext;
          first_d     = 1'b0;
        end
      end
      SETTLE: begin
        // The last strobe's effect is visible on calc_result during SETTLE.
        if (!aborting) begin
          sum_d = calc_result;
          err_d = (calc_result != shadow);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed bench for calc_sequencer with a calculator model
module tb_calc_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic        op_valid = 1'b0, corrupt = 1'b0;
  logic [7:0]  count = '0;
  logic [15:0] op_data = '0;
  logic        busy, op_ready, calc_clear, calc_load, calc_add, done, err;
  logic [15:0] calc_dIn;
  logic [31:0] calc_result, sum;
  logic [31:0] acc = '0;
  int asserts = 0, fails = 0, cyc = 0, n_done = 0, done_cyc = 0;
  int log[$];

  calc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .abort(abort), .busy(busy),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .calc_dIn(calc_dIn),
    .calc_clear(calc_clear), .calc_load(calc_load), .calc_add(calc_add),
    .calc_result(calc_result), .sum(sum), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (calc_clear) acc <= '0;
    else if (calc_load) acc <= {16'h0, calc_dIn};
    else if (calc_add) acc <= acc + {16'h0, calc_dIn};
  end
  assign calc_result = acc + {31'b0, corrupt};

  always @(negedge clk) begin
    if (calc_clear) log.push_back(1);
    if (calc_load) log.push_back(2);
    if (calc_add) log.push_back(3);
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  function automatic int seq_code(input int from);
    int c = 0;
    for (int i = from; i < log.size(); i++) c = c * 4 + log[i];
    return c;
  endfunction

  task automatic start_job(input logic [7:0] n, output int st);
    @(posedge clk); #1;
    start = 1'b1; count = n; st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2);
    logic [15:0] v[3];
    int i = 0, g = 0;
    logic hs;
    v[0] = d0; v[1] = d1; v[2] = d2;
    op_valid = 1'b1; op_data = v[0];
    while (i < n && g < 200) begin
      @(negedge clk); hs = op_ready; g++;
      @(posedge clk); #1;
      if (hs) begin
        i++;
        if (i < n) op_data = v[i];
        else op_valid = 1'b0;
      end
    end
    op_valid = 1'b0;
    asserts++;
    if (i != n) begin fails++; $display("FAIL feed_timeout: accepted %0d required %0d", i, n); end
  endtask

  task automatic wait_done(input int snap, input int st, output int lat);
    int g = 0;
    while (n_done == snap && g < 100) begin @(negedge clk); #1; g++; end
    asserts++;
    lat = -1;
    if (n_done == snap) begin fails++; $display("FAIL done_timeout: no done within %0d cycles", g); end
    else lat = done_cyc - st;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    asserts += 9;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (op_ready !== 1'b0) begin fails++; $display("FAIL rst_op_ready: got %b required 0", op_ready); end
    if (calc_dIn !== 16'h0) begin fails++; $display("FAIL rst_dIn: got %h required 0", calc_dIn); end
    if (calc_clear !== 1'b0) begin fails++; $display("FAIL rst_clear: got %b required 0", calc_clear); end
    if (calc_load !== 1'b0) begin fails++; $display("FAIL rst_load: got %b required 0", calc_load); end
    if (calc_add !== 1'b0) begin fails++; $display("FAIL rst_add: got %b required 0", calc_add); end
    if (sum !== 32'h0) begin fails++; $display("FAIL rst_sum: got %h required 0", sum); end
    if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", done); end
    if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", err); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_job;
    int st, g = 0;
    op_valid = 1'b1; op_data = 16'h00AA;
    start_job(8'd3, st);
    while (calc_load !== 1'b1 && g < 20) begin @(negedge clk); #1; g++; end
    asserts++;
    if (calc_load !== 1'b1) begin fails++; $display("FAIL midrst_reach_issue: load %b required 1", calc_load); end
    reset = 1'b1;
    #1;
    asserts++;
    if ({busy, op_ready, calc_dIn, calc_clear, calc_load, calc_add, sum, done, err} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: busy %b rdy %b dIn %h clr %b ld %b add %b sum %h done %b err %b required all 0",
               busy, op_ready, calc_dIn, calc_clear, calc_load, calc_add, sum, done, err);
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    asserts++;
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_basic_sum;
    int st, lat, snap = n_done, lsnap = log.size();
    start_job(8'd3, st);
    feed(3, 16'h0001, 16'hFFFF, 16'h0002);
    wait_done(snap, st, lat);
    asserts += 4;
    if (lat !== 9) begin fails++; $display("FAIL basic_latency: got %0d required 9", lat); end
    if (sum !== 32'h0001_0002) begin fails++; $display("FAIL basic_sum: got %h required 00010002", sum); end
    if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b required 0", err); end
    if (seq_code(lsnap) !== 111) begin fails++; $display("FAIL basic_strobe_order: got code %0d required 111", seq_code(lsnap)); end
  endtask

  task automatic test_zero_count;
    int st, lat, snap = n_done, lsnap = log.size();
    start_job(8'd0, st);
    wait_done(snap, st, lat);
    asserts += 4;
    if (lat !== 3) begin fails++; $display("FAIL zero_latency: got %0d required 3", lat); end
    if (sum !== 32'h0) begin fails++; $display("FAIL zero_sum: got %h required 0", sum); end
    if (err !== 1'b0) begin fails++; $display("FAIL zero_err: got %b required 0", err); end
    if (seq_code(lsnap) !== 1) begin fails++; $display("FAIL zero_strobes: got code %0d required 1", seq_code(lsnap)); end
  endtask

  task automatic test_stall;
    int st, lat, snap = n_done, lsnap = log.size();
    op_valid = 1'b0;
    start_job(8'd2, st);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      asserts++;
      if (op_ready !== 1'b1) begin fails++; $display("FAIL stall_op_ready cycle %0d: got %b required 1", i, op_ready); end
      @(posedge clk); #1;
    end
    asserts++;
    if (seq_code(lsnap) !== 1) begin fails++; $display("FAIL stall_no_strobes: got code %0d required 1", seq_code(lsnap)); end
    feed(2, 16'h1234, 16'h0010, 16'h0000);
    wait_done(snap, st, lat);
    asserts += 2;
    if (sum !== 32'h0000_1244) begin fails++; $display("FAIL stall_sum: got %h required 00001244", sum); end
    if (err !== 1'b0) begin fails++; $display("FAIL stall_err: got %b required 0", err); end
  endtask

  task automatic test_abort;
    int st, snap = n_done, lsnap = log.size();
    start_job(8'd4, st);
    feed(2, 16'h000A, 16'h000B, 16'h0000);
    start = 1'b1; count = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    asserts += 3;
    if (calc_clear !== 1'b1) begin fails++; $display("FAIL abort_clear: got %b required 1", calc_clear); end
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (op_ready !== 1'b0) begin fails++; $display("FAIL abort_op_ready: got %b required 0", op_ready); end
    repeat (20) @(negedge clk);
    #1;
    asserts += 5;
    if (n_done !== snap) begin fails++; $display("FAIL abort_no_done: got %0d dones required 0", n_done - snap); end
    if (sum !== 32'h0000_1244) begin fails++; $display("FAIL abort_sum_held: got %h required 00001244", sum); end
    if (err !== 1'b0) begin fails++; $display("FAIL abort_err_held: got %b required 0", err); end
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_no_second_job: busy %b required 0", busy); end
    if (seq_code(lsnap) !== 109) begin fails++; $display("FAIL abort_strobes: got code %0d required 109", seq_code(lsnap)); end
  endtask

  task automatic test_mismatch;
    int st, lat, snap;
    corrupt = 1'b1;
    snap = n_done;
    start_job(8'd2, st);
    feed(2, 16'h0005, 16'h0003, 16'h0000);
    wait_done(snap, st, lat);
    asserts += 3;
    if (lat !== 7) begin fails++; $display("FAIL mism_latency: got %0d required 7", lat); end
    if (sum !== 32'h0000_0009) begin fails++; $display("FAIL mism_sum: got %h required 00000009", sum); end
    if (err !== 1'b1) begin fails++; $display("FAIL mism_err: got %b required 1", err); end
    corrupt = 1'b0;
    snap = n_done;
    start_job(8'd1, st);
    feed(1, 16'h0007, 16'h0000, 16'h0000);
    wait_done(snap, st, lat);
    asserts += 2;
    if (sum !== 32'h0000_0007) begin fails++; $display("FAIL clean_sum: got %h required 00000007", sum); end
    if (err !== 1'b0) begin fails++; $display("FAIL clean_err_cleared: got %b required 0", err); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_basic_sum();
    test_zero_count();
    test_stall();
    test_abort();
    test_mismatch();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
